// File: rtl/digit_pkg.sv
// digit_pkg: shared types and constants for the counter-driven digit source.
//   digit_t      : 4-bit digit value as consumed by the seven-segment decoder
//   state_t      : STOP (manual/load only) or RUN (auto-count from prescaler)
//   MAX_DIGIT    : terminal count, 9 (decimal) or 15 when DIGIT_COUNTER_HEX_EN
//   clamp_digit(): limits a loaded value to the legal digit range
// Build option: `define DIGIT_COUNTER_HEX_EN selects the full hexadecimal range.
package digit_pkg;

  localparam int NBITS = 4;

  typedef logic [NBITS-1:0] digit_t;

  localparam digit_t MAX_DEC = 4'd9;
  localparam digit_t MAX_HEX = 4'd15;

`ifdef DIGIT_COUNTER_HEX_EN
  localparam digit_t MAX_DIGIT = MAX_HEX;
`else
  localparam digit_t MAX_DIGIT = MAX_DEC;
`endif

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Loaded values above the terminal count are pinned to it so the digit
  // can never leave the displayable range.
  function automatic digit_t clamp_digit(digit_t v);
`ifdef DIGIT_COUNTER_HEX_EN
    return v;
`else
    return (v > MAX_DIGIT) ? MAX_DIGIT : v;
`endif
  endfunction

endpackage

// File: rtl/rise_edge.sv
// rise_edge: single-cycle pulse on the rising edge of a level input.
// Intended for already-debounced board buttons; holding the input high
// yields exactly one pulse.
//   clk_2   : clock
//   reset   : synchronous active-high reset, clears the edge history
//   in_i    : level input
//   pulse_o : high for the one cycle where in_i=1 and it was 0 last cycle
module rise_edge (
  input  logic clk_2,
  input  logic reset,
  input  logic in_i,
  output logic pulse_o
);

  logic in_q;

  always_ff @(posedge clk_2) begin
    if (reset) in_q <= 1'b0;
    else       in_q <= in_i;
  end

  assign pulse_o = in_i & ~in_q;

endmodule

// File: rtl/digit_counter.sv
// digit_counter: sequential digit source for the seven-segment decoder stage.
// Counts up/down automatically from a prescaled tick (RUN) or manually from
// a step button, with parallel load. All outputs are registered.
//   clk_2    : clock, all updates on rising edge
//   reset    : synchronous active-high reset (highest priority)
//   en       : 1 = RUN, 0 = STOP
//   up       : 1 = increment, 0 = decrement
//   step_btn : manual step, acted on at its rising edge (both states)
//   load     : parallel load strobe, beats any advance in the same cycle
//   load_val : value to load (clamped to MAX_DIGIT)
//   digit    : current count
//   dp       : decimal point, 1 while RUN and digit != 0
//   carry    : one-cycle pulse in the cycle the wrapped digit appears
// Parameters: PRESC_DIV (>=1) clk_2 cycles per auto tick; NBITS_DIGIT is
// fixed at 4 and only sizes the digit ports.
// Build option: DIGIT_COUNTER_HEX_EN widens the range to 0..15.
module digit_counter
  import digit_pkg::*;
#(
  parameter int PRESC_DIV   = 4,
  parameter int NBITS_DIGIT = 4
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   up,
  input  logic                   step_btn,
  input  logic                   load,
  input  logic [NBITS_DIGIT-1:0] load_val,
  output logic [NBITS_DIGIT-1:0] digit,
  output logic                   dp,
  output logic                   carry
);

  // Keep at least one prescaler bit so PRESC_DIV=1 still elaborates.
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  digit_t          digit_q, digit_d;
  logic            carry_q, carry_d;
  logic            dp_q, dp_d;

  logic            step_pulse;
  logic            tick;
  logic            advance;

  rise_edge u_step_edge (
    .clk_2   (clk_2),
    .reset   (reset),
    .in_i    (step_btn),
    .pulse_o (step_pulse)
  );

  // Tick only exists in RUN; the prescaler sits at 0 in STOP, so the first
  // tick lands PRESC_DIV cycles after entering RUN.
  assign tick    = (state_q == RUN) && (presc_q == PRESC_LAST);
  // OR, not sum: a step coinciding with a tick is a single advance.
  assign advance = tick | step_pulse;

  always_comb begin
    state_d = en ? RUN : STOP;
  end

  // Load does not touch the prescaler, so RUN cadence survives a load.
  always_comb begin
    presc_d = '0;
    if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  // Wrap is decoded explicitly against MAX_DIGIT; >= guards the decimal
  // build against ever emitting 10..15.
  always_comb begin
    digit_d = digit_q;
    carry_d = 1'b0;
    if (load) begin
      digit_d = clamp_digit(digit_t'(load_val));
    end else if (advance) begin
      if (up) begin
        if (digit_q >= MAX_DIGIT) begin
          digit_d = '0;
          carry_d = 1'b1;
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end else begin
        if (digit_q == '0) begin
          digit_d = MAX_DIGIT;
          carry_d = 1'b1;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end
    end
  end

  // dp looks at next-state values so it lines up with the registered digit.
  always_comb begin
    dp_d = (state_d == RUN) && (digit_d != '0);
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= STOP;
      presc_q <= '0;
      digit_q <= '0;
      carry_q <= 1'b0;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      digit_q <= digit_d;
      carry_q <= carry_d;
      dp_q    <= dp_d;
    end
  end

  assign digit = NBITS_DIGIT'(digit_q);
  assign carry = carry_q;
  assign dp    = dp_q;

endmodule

// File: tb/tb_digit_counter.sv
module tb_digit_counter;

`ifdef DIGIT_COUNTER_HEX_EN
  localparam int MAXD = 15;
`else
  localparam int MAXD = 9;
`endif

  typedef struct {
    logic       rst, en, up, stp, ld;
    logic [3:0] lv;
    logic [3:0] d;
    logic       c, dp;
  } vec_t;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, up = 1'b1, step_btn = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] digit;
  logic       dp, carry;

  int n_chk = 0;
  int n_fail = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  digit_counter #(.PRESC_DIV(4), .NBITS_DIGIT(4)) dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .step_btn (step_btn),
    .load     (load),
    .load_val (load_val),
    .digit    (digit),
    .dp       (dp),
    .carry    (carry)
  );

  always #5 clk_2 = ~clk_2;

  function automatic int cl(int v);
    return (v > MAXD) ? MAXD : v;
  endfunction

  function automatic vec_t mk(bit r, bit e, bit u, bit s, bit l, int lv,
                              int d, bit c, bit p);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.stp = s; v.ld = l;
    v.lv = 4'(lv); v.d = 4'(d); v.c = c; v.dp = p;
    return v;
  endfunction

  task automatic chk(input int tag);
    vec_t v;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_empty tag=%0d", tag);
      return;
    end
    v = exp_q.pop_front();
    n_chk++;
    if (digit !== v.d) begin
      n_fail++;
      $display("FAIL digit tag=%0d got=%0d exp=%0d", tag, digit, v.d);
    end
    n_chk++;
    if (carry !== v.c) begin
      n_fail++;
      $display("FAIL carry tag=%0d got=%b exp=%b", tag, carry, v.c);
    end
    n_chk++;
    if (dp !== v.dp) begin
      n_fail++;
      $display("FAIL dp tag=%0d got=%b exp=%b", tag, dp, v.dp);
    end
  endtask

  // Drive on the falling edge, compare 1 time unit after the rising edge.
  task automatic run_vec(input vec_t v, input int tag);
    @(negedge clk_2);
    reset = v.rst; en = v.en; up = v.up; step_btn = v.stp;
    load = v.ld; load_val = v.lv;
    exp_q.push_back(v);
    @(posedge clk_2);
    #1;
    chk(tag);
  endtask

  initial begin
    int d;
    bit c;

    // Reset state
    run_vec(mk(1,0,1,0,0,0, 0,0,0), 0);
    run_vec(mk(1,0,1,0,0,0, 0,0,0), 1);

    // Auto count: after the k-th RUN edge digit = (k/4) mod (MAXD+1)
    for (int k = 0; k < 48; k++) begin
      d = (k / 4) % (MAXD + 1);
      c = (k > 0) && (k % 4 == 0) && (d == 0);
      run_vec(mk(0,1,1,0,0,0, d, c, d != 0), 100 + k);
    end

    // Drop en with a tick due: last tick still lands, dp follows next state
    tbl.push_back(mk(0,0,1,0,0,0, 12 % (MAXD+1), 0, 0));
    tbl.push_back(mk(0,0,1,0,0,0, 12 % (MAXD+1), 0, 0));
    // Down-wrap from 0 via held step: one advance only
    tbl.push_back(mk(0,0,0,0,1,0, 0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0, MAXD,1,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,1,0,0, MAXD,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, MAXD,0,0));
    // Loads and clamping, load beating a step pulse
    tbl.push_back(mk(0,0,0,0,1,12, cl(12),0,0));
    tbl.push_back(mk(0,0,0,0,1,3,  3,0,0));
    tbl.push_back(mk(0,0,0,1,1,6,  6,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,  6,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,  6,0,0));
    tbl.push_back(mk(0,0,0,0,1,10, cl(10),0,0));
    tbl.push_back(mk(0,0,0,0,1,15, cl(15),0,0));
    // Up-wrap at the terminal count via steps
    tbl.push_back(mk(0,0,1,0,1,MAXD-1, MAXD-1,0,0));
    tbl.push_back(mk(0,0,1,1,0,0, MAXD,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, MAXD,0,0));
    tbl.push_back(mk(0,0,1,1,0,0, 0,1,0));
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,1,1,0,0, 1,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 1,0,0));
    // Reset beats load
    tbl.push_back(mk(1,0,1,0,1,5, 0,0,0));
    // Load 5 while entering RUN, step coincident with tick -> 6 not 7
    tbl.push_back(mk(0,1,1,0,1,5, 5,0,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,1,0,0,0, 5,0,1));
    tbl.push_back(mk(0,1,1,1,0,0, 6,0,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,1,0,0,0, 6,0,1));
    tbl.push_back(mk(0,1,1,0,0,0, 7,0,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,1,0,0,0, 7,0,1));
    // Reset with tick due, then 4 quiet RUN cycles before the first tick
    tbl.push_back(mk(1,1,1,0,0,0, 0,0,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,1,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 1,0,1));
    // Down count in RUN with a mid-period step
    tbl.push_back(mk(0,1,0,1,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,0));

    foreach (tbl[i]) run_vec(tbl[i], 200 + i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop so the run cannot hang.
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
